// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative DIV/DIVU controller.
// The state encoding matches the pipeline's legacy Div* macro values.
package div_ctrl_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage divide request/result bundle.
// The master drives the request, and the slave (div_ctrl) returns results and the stall.
interface div_ctrl_if #(
    parameter int DATA_W = div_ctrl_pkg::DIV_DATA_W
);

    logic              flush;
    logic              div_start;
    logic              signed_div;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              ready;
    logic              stallreq_from_ex;

    modport master (
        output flush, div_start, signed_div, dividend, divisor,
        input  quotient, remainder, ready, stallreq_from_ex
    );

    modport slave (
        input  flush, div_start, signed_div, dividend, divisor,
        output quotient, remainder, ready, stallreq_from_ex
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in one dividend bit, do a trial
// subtract of the divisor, and keep the shifted value if the subtract borrows.
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W:0]   prem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   prem_out,
    output logic              quo_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            borrow;

    always_comb begin
        shifted       = {prem_in[DATA_W-1:0], dvd_bit};
        {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
        // A set bit shifted out of the top means the true value already exceeds the divisor.
        quo_bit  = prem_in[DATA_W] | ~borrow;
        prem_out = quo_bit ? diff : shifted;
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller: FSM, iteration counter, operand registers and
// sign fix-up around a combinational restoring step. It stalls EX until ready.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic     clk,
    input  logic     resetn,
    div_ctrl_if.slave bus
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W:0]   prem_q, prem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic [DATA_W:0]   step_prem;
    logic              step_quo;

    function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    div_step #(.DATA_W(DATA_W)) u_step (
        .prem_in  (prem_q),
        .dvd_bit  (dvd_q[DATA_W-1]),
        .divisor  (dvs_q),
        .prem_out (step_prem),
        .quo_bit  (step_quo)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = DIV_RESULT_NOT_READY;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;

        if (bus.flush) begin
            state_d = DIV_FREE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    if (bus.div_start == DIV_START) begin
                        dvd_d     = abs_op(bus.dividend, bus.signed_div);
                        dvs_d     = abs_op(bus.divisor, bus.signed_div);
                        neg_quo_d = bus.signed_div & (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
                        neg_rem_d = bus.signed_div & bus.dividend[DATA_W-1];
                        prem_d    = '0;
                        cnt_d     = '0;
                        state_d   = (bus.divisor == '0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end

                DIV_BY_ZERO: begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    ready_d     = DIV_RESULT_READY;
                    state_d     = DIV_END;
                end

                DIV_ON: begin
                    // Quotient bits shift into the low end as the dividend shifts out the top.
                    prem_d = step_prem;
                    dvd_d  = {dvd_q[DATA_W-2:0], step_quo};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        quotient_d  = neg_quo_q ? -dvd_d : dvd_d;
                        remainder_d = neg_rem_q ? -step_prem[DATA_W-1:0] : step_prem[DATA_W-1:0];
                        cnt_d       = '0;
                        ready_d     = DIV_RESULT_READY;
                        state_d     = DIV_END;
                    end
                end

                DIV_END: begin
                    state_d = DIV_FREE;
                end

                default: begin
                    state_d = DIV_FREE;
                end
            endcase
        end
    end

    // NOTE: operand and partial-remainder registers are reset too, so an abandoned
    // operation leaves nothing behind; state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= DIV_FREE;
            cnt_q       <= '0;
            ready_q     <= DIV_RESULT_NOT_READY;
            quotient_q  <= '0;
            remainder_q <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
        end
    end

    assign bus.quotient         = quotient_q;
    assign bus.remainder        = remainder_q;
    assign bus.ready            = ready_q;
    assign bus.stallreq_from_ex = bus.div_start && (ready_q != DIV_RESULT_READY);

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle controller and iterative datapath for the 32-bit DIV/DIVU instructions in the EX stage.
- Sequences a radix-2 restoring divider over 32 iterations.
- Drives the EX stall request into the pipeline stall controller.
- Returns quotient (LO) and remainder (HI) for the HI/LO write in the same cycle the stall releases.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  annul the in-flight operation (exception or pipeline flush).
- div_start  input  1  EX holds a DIV/DIVU; held high until ready is seen.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled at launch only.
- dividend  input  DATA_W  rs operand; sampled at launch only.
- divisor  input  DATA_W  rt operand; sampled at launch only.
- quotient  output  DATA_W  LO result, registered.
- remainder  output  DATA_W  HI result, registered.
- ready  output  1  result valid; high for exactly one cycle per operation.
- stallreq_from_ex  output  1  combinational: div_start && !ready.

Behaviour:
- Reset (resetn low, async): state IDLE, counter 0, quotient 0, remainder 0, ready 0. Reset mid-operation abandons the operation with no residual state.
- States:
  - IDLE: if div_start && !flush, latch operands and signed_div. If divisor==0 go DIVZERO, else go ON with counter 0.
  - DIVZERO: one cycle; load quotient=0, remainder=0; go END.
  - ON: one restoring step per cycle; counter increments. After step 32 (counter==DATA_W-1), write the sign-corrected results and go END.
  - END: ready=1 for one cycle; go IDLE unconditionally.
- flush has priority in every state: next state IDLE, counter 0, ready 0. Result registers keep their old values.
- Latency, with launch cycle = 0:
  - Normal path: ON during cycles 1..32, END (ready) at cycle 33. stallreq_from_ex is high in cycles 0..32 and low in cycle 33.
  - Divide-by-zero path: DIVZERO at cycle 1, ready at cycle 2.
- Back-to-back DIVs: the second div_start is seen in IDLE the cycle after END and launches normally. A result is never reused.
- div_start low in IDLE: no state change, stallreq_from_ex 0.
- div_start dropping during ON (only possible via flush) is covered by the flush rule. Without flush the controller completes the operation and ignores div_start.
- Datapath:
  - Signed mode: divide absolute values of the operands.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - All negation is modulo 2^DATA_W, so 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
  - Partial remainder register is DATA_W+1 bits wide so the trial-subtract borrow can be detected.
- quotient and remainder stay stable from END until the next result write.

Decomposition:
- lib/defines.vh gains the following; CNT_W and DATA_W are used directly by div_ctrl.
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
- One combinational sub-module, div_step.
  - Inputs: partial remainder and the next dividend bit.
  - Outputs: new partial remainder and one quotient bit (trial subtract with restore).
  - div_ctrl keeps the FSM, counter, operand registers and sign fix-up.

Test Plan:
- DIVU 100 / 7, div_start held → stallreq_from_ex high cycles 0..32; ready at cycle 33 only; quotient=14, remainder=2.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 (either mode) → ready at cycle 2; quotient=0, remainder=0; stall high cycles 0..1 only.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; no hang, ready at cycle 33.
- Flush at cycle 10 → IDLE at cycle 11, no ready pulse, old results unchanged. A relaunch of 50 / 5 gives quotient 10, remainder 0 at relaunch+33.
- resetn pulled low asynchronously at cycle 15 → ready, quotient and remainder read 0 before the next clock edge; state IDLE. Two back-to-back DIVUs (9/4 then 9/2) → ready pulses 34 cycles apart, results 2/1 then 4/1.
